// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Requests are held until a one-cycle mem_ready pulse completes them.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: alignment check, byte enables, store-lane replication, load
// extraction/extension, and a request/wait/done FSM with a bus timeout.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               is_store,
    input  logic [2:0]         op,
    input  logic [31:0]        addr,
    input  logic [31:0]        store_data,
    output logic               stall,
    output logic [31:0]        load_data,
    output logic               load_valid,
    output logic               misaligned,
    output logic               bus_error,
    mem_access_unit_if.master  mem
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_store;
    logic [2:0]        r_op;
    logic [1:0]        r_addr_lo;
    logic              r_req, r_we;
    logic [29:0]       r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_load_data;
    logic              r_load_valid, r_bus_error;

    logic [1:0]        w_size;
    logic              w_start, w_timeout;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [31:0]       w_load_ext;

    assign w_size     = op[1:0];
    assign misaligned = en & ((w_size == 2'b11) |
                              ((w_size == 2'b01) & addr[0]) |
                              ((w_size == 2'b10) & (addr[1:0] != 2'b00)));
    assign w_start    = (r_state == S_IDLE) & en & ~misaligned;
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Per-lane enable and replicated write data; half-word lanes pick the low or high half.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_be[gi] = (w_size == 2'b00) ? (addr[1:0] == 2'(gi)) :
                          (w_size == 2'b01) ? (addr[1] == (gi >= 2)) : 1'b1;
        assign w_wdata[8*gi +: 8] = (w_size == 2'b00) ? store_data[7:0] :
                                    (w_size == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                                        store_data[8*gi +: 8];
    end

    assign w_lane_byte = mem.mem_rdata[{r_addr_lo, 3'b000} +: 8];
    assign w_lane_half = r_addr_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        w_load_ext = mem.mem_rdata;
        case (r_op[1:0])
            2'b00:   w_load_ext = r_op[2] ? {24'h0, w_lane_byte}
                                          : {{24{w_lane_byte[7]}}, w_lane_byte};
            2'b01:   w_load_ext = r_op[2] ? {16'h0, w_lane_half}
                                          : {{16{w_lane_half[15]}}, w_lane_half};
            default: w_load_ext = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    stall        = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem.mem_ready || w_timeout) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_is_store   <= 1'b0;
            r_op         <= '0;
            r_addr_lo    <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_is_store <= is_store;
                        r_op       <= op;
                        r_addr_lo  <= addr[1:0];
                        r_req      <= 1'b1;
                        r_we       <= is_store;
                        r_addr     <= addr[31:2];
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A ready pulse on the timeout cycle still counts as a good completion.
                    if (mem.mem_ready) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        if (!r_is_store) begin
                            r_load_data  <= w_load_ext;
                            r_load_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_req        <= 1'b0;
                        r_we         <= 1'b0;
                        r_bus_error  <= 1'b1;
                        r_load_data  <= '0;
                        r_load_valid <= ~r_is_store;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;
    assign load_data     = r_load_data;
    assign load_valid    = r_load_valid;
    assign bus_error     = r_bus_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, extended loads, misalignment,
// timeout and mid-access reset, with hand-computed expectations.
module tb_mem_access_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset, en, is_store;
    logic [2:0]  op;
    logic [31:0] addr, store_data;
    logic        stall, load_valid, misaligned, bus_error;
    logic [31:0] load_data;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          nst;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .is_store   (is_store),
        .op         (op),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .mem        (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({31'b0, stall},        32'h0, {tag, " stall"});
        chk({31'b0, load_valid},   32'h0, {tag, " load_valid"});
        chk({31'b0, bus_error},    32'h0, {tag, " bus_error"});
        chk({31'b0, bus.mem_req},  32'h0, {tag, " mem_req"});
        chk({31'b0, bus.mem_we},   32'h0, {tag, " mem_we"});
        chk({28'b0, bus.mem_be},   32'h0, {tag, " mem_be"});
        chk({2'b0, bus.mem_addr},  32'h0, {tag, " mem_addr"});
        chk(bus.mem_wdata,         32'h0, {tag, " mem_wdata"});
        chk(load_data,             32'h0, {tag, " load_data"});
    endtask

    // One full access; rdy_at = WAIT-cycle index of the ready pulse, -1 = never.
    task automatic access(input logic st, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] sd, input int rdy_at, input logic [31:0] rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_ld, input logic exp_lv, input logic exp_err,
                          input string tag, output int nstall);
        en = 1'b1; is_store = st; op = o; addr = a; store_data = sd;
        #1;
        chk({31'b0, stall},       32'h1, {tag, " stall_issue"});
        chk({31'b0, misaligned},  32'h0, {tag, " misaligned"});
        nstall = 1;
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            bus.mem_ready = (i == rdy_at);
            bus.mem_rdata = (i == rdy_at) ? rd : 32'h0;
            #1;
            chk({31'b0, bus.mem_req}, 32'h1, {tag, " mem_req"});
            chk({31'b0, stall},       32'h1, {tag, " stall_wait"});
            if (i == 0) begin
                chk({31'b0, bus.mem_we}, {31'b0, st}, {tag, " mem_we"});
                chk({2'b0, bus.mem_addr}, {2'b0, a[31:2]}, {tag, " mem_addr"});
                chk({28'b0, bus.mem_be}, {28'b0, exp_be}, {tag, " mem_be"});
                if (st) chk(bus.mem_wdata, exp_wd, {tag, " mem_wdata"});
            end
            nstall++;
            if (i == rdy_at) break;
        end
        step();
        bus.mem_ready = 1'b0;
        en = 1'b0;
        #1;
        chk({31'b0, stall},       32'h0, {tag, " stall_done"});
        chk({31'b0, bus.mem_req}, 32'h0, {tag, " req_done"});
        chk({31'b0, load_valid},  {31'b0, exp_lv},  {tag, " load_valid"});
        chk({31'b0, bus_error},   {31'b0, exp_err}, {tag, " bus_error"});
        if (exp_lv) chk(load_data, exp_ld, {tag, " load_data"});
        step();
        chk({31'b0, load_valid}, 32'h0, {tag, " lv_pulse"});
        chk({31'b0, bus_error},  32'h0, {tag, " err_pulse"});
        chk({31'b0, stall},      32'h0, {tag, " stall_idle"});
        $display("txn %s: stall cycles %0d load_data 0x%08h", tag, nstall, load_data);
    endtask

    task automatic misalign(input logic [2:0] o, input logic [31:0] a, input logic st,
                            input string tag);
        en = 1'b1; is_store = st; op = o; addr = a; store_data = 32'hFFFFFFFF;
        #1;
        chk({31'b0, misaligned}, 32'h1, {tag, " misaligned"});
        chk({31'b0, stall},      32'h0, {tag, " stall"});
        step();
        chk({31'b0, bus.mem_req}, 32'h0, {tag, " mem_req"});
        chk({31'b0, stall},       32'h0, {tag, " stall_next"});
        en = 1'b0;
        #1;
        chk({31'b0, misaligned}, 32'h0, {tag, " misaligned_en0"});
        $display("txn %s: misaligned access rejected", tag);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; is_store = 1'b0; op = 3'b0; addr = 32'h0;
        store_data = 32'h0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) step();
        check_idle_zero("reset");
        reset = 1'b0;
        step();

        access(1'b1, 3'b010, 32'h10010008, 32'hDEADBEEF, 2, 32'h0, 4'b1111, 32'hDEADBEEF,
               32'h0, 1'b0, 1'b0, "SW", nst);
        chk(nst, 4, "SW stall_cycles");
        access(1'b1, 3'b000, 32'h1001000B, 32'h0000007F, 0, 32'h0, 4'b1000, 32'h7F7F7F7F,
               32'h0, 1'b0, 1'b0, "SB", nst);
        access(1'b1, 3'b001, 32'h1001000A, 32'h12345678, 1, 32'h0, 4'b1100, 32'h56785678,
               32'h0, 1'b0, 1'b0, "SH", nst);
        access(1'b0, 3'b000, 32'h1001000B, 32'h0, 0, 32'hDEADBEEF, 4'b1000, 32'h0,
               32'hFFFFFFDE, 1'b1, 1'b0, "LB", nst);
        chk(nst, 2, "LB stall_cycles");
        access(1'b0, 3'b100, 32'h1001000B, 32'h0, 0, 32'hDEADBEEF, 4'b1000, 32'h0,
               32'h000000DE, 1'b1, 1'b0, "LBU", nst);
        access(1'b0, 3'b100, 32'h10010009, 32'h0, 0, 32'hDEADBEEF, 4'b0010, 32'h0,
               32'h000000BE, 1'b1, 1'b0, "LBU1", nst);
        access(1'b0, 3'b000, 32'h10010008, 32'h0, 0, 32'h1234567F, 4'b0001, 32'h0,
               32'h0000007F, 1'b1, 1'b0, "LBpos", nst);
        access(1'b0, 3'b001, 32'h1001000A, 32'h0, 0, 32'hDEADBEEF, 4'b1100, 32'h0,
               32'hFFFFDEAD, 1'b1, 1'b0, "LH", nst);
        access(1'b0, 3'b101, 32'h10010008, 32'h0, 0, 32'hDEADBEEF, 4'b0011, 32'h0,
               32'h0000BEEF, 1'b1, 1'b0, "LHU", nst);
        access(1'b0, 3'b010, 32'h10010008, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 32'h0,
               32'hDEADBEEF, 1'b1, 1'b0, "LW", nst);

        misalign(3'b010, 32'h1001000A, 1'b0, "LWmis");
        misalign(3'b011, 32'h10010008, 1'b0, "SZ11");
        misalign(3'b001, 32'h10010009, 1'b1, "SHmis");

        // Timeout on the last WAIT cycle: mem_req high for TIMEOUT cycles.
        access(1'b0, 3'b010, 32'h10010008, 32'h0, -1, 32'h0, 4'b1111, 32'h0,
               32'h00000000, 1'b1, 1'b1, "LWtimeout", nst);
        chk(nst, TIMEOUT + 1, "timeout stall_cycles");
        chk(load_data, 32'h0, "timeout load_data_held");

        // Ready exactly on the timeout cycle wins: no bus error.
        access(1'b0, 3'b010, 32'h10010004, 32'h0, TIMEOUT - 1, 32'hCAFEF00D, 4'b1111, 32'h0,
               32'hCAFEF00D, 1'b1, 1'b0, "LWlate", nst);

        // Reset in WAIT, then a late ready while IDLE.
        en = 1'b1; is_store = 1'b1; op = 3'b010; addr = 32'h20000004; store_data = 32'hA5A5A5A5;
        step();
        step();
        chk({31'b0, bus.mem_req}, 32'h1, "rst_pre mem_req");
        reset = 1'b1;
        step();
        reset = 1'b0; en = 1'b0;
        #1;
        check_idle_zero("rst_wait");
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11223344;
        step();
        bus.mem_ready = 1'b0;
        #1;
        check_idle_zero("late_ready");
        step();
        check_idle_zero("late_ready2");
        $display("txn RSTWAIT: reset mid-access, late ready ignored");

        access(1'b0, 3'b001, 32'h10010002, 32'h0, 0, 32'h80017FFF, 4'b1100, 32'h0,
               32'hFFFF8001, 1'b1, 1'b0, "B2B_LH", nst);
        access(1'b1, 3'b000, 32'h10010001, 32'h000000C3, 0, 32'h0, 4'b0010, 32'hC3C3C3C3,
               32'h0, 1'b0, 1'b0, "B2B_SB", nst);
        chk(load_data, 32'hFFFF8001, "store_keeps_load_data");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
